// File: rtl/jt51_timer_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | jt51_timer_ctrl_pkg                                                        |
// | Register addresses, control-bit indices and command bundle for the timer   |
// | register front end.                                                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package jt51_timer_ctrl_pkg;

    localparam logic [7:0] ADDR_CLKA1 = 8'h10;
    localparam logic [7:0] ADDR_CLKA2 = 8'h11;
    localparam logic [7:0] ADDR_CLKB  = 8'h12;
    localparam logic [7:0] ADDR_TCTRL = 8'h14;

    localparam int TCTRL_CSM     = 7;
    localparam int TCTRL_FRES_B  = 5;
    localparam int TCTRL_FRES_A  = 4;
    localparam int TCTRL_IRQEN_B = 3;
    localparam int TCTRL_IRQEN_A = 2;
    localparam int TCTRL_LOAD_B  = 1;
    localparam int TCTRL_LOAD_A  = 0;

    localparam int STATUS_BUSY_BIT = 7;
    localparam int BUSY_CNT_W      = 8;

    typedef struct packed {
        logic load_a;
        logic load_b;
        logic clr_run_a;
        logic clr_run_b;
        logic clr_flag_a;
        logic clr_flag_b;
    } tmr_cmd_t;

endpackage

`default_nettype wire

// File: rtl/jt51_timer_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | jt51_timer_ctrl_if                                                         |
// | Host bus connection: chip select, write strobe, port select, data in/out.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface jt51_timer_ctrl_if;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs_n, output wr_n, output a0, output din, input dout);
    modport slave  (input cs_n, input wr_n, input a0, input din, output dout);
endinterface

`default_nettype wire

// File: rtl/jt51_busy_cnt.sv
// +----------------------------------------------------------------------------+
// | jt51_busy_cnt                                                              |
// | Busy counter: reloads on a data write, counts down on cen cycles.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module jt51_busy_cnt
    import jt51_timer_ctrl_pkg::*;
#(
    parameter int BUSY_CYC = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic cen,
    input  wire logic load,
    output logic      busy
);

    logic [BUSY_CNT_W-1:0] cnt_q;
    logic [BUSY_CNT_W-1:0] cnt_d;

    // A reload wins over a same-cycle decrement so a write always restarts the full window.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = BUSY_CNT_W'(BUSY_CYC);
        end else if (cen && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/jt51_timer_ctrl.sv
// +----------------------------------------------------------------------------+
// | jt51_timer_ctrl                                                            |
// | Decodes timer register writes into timer commands and returns the status.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module jt51_timer_ctrl
    import jt51_timer_ctrl_pkg::*;
#(
    parameter int BUSY_CYC = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         cen,
    jt51_timer_ctrl_if.slave  bus,
    output logic [9:0]        value_A,
    output logic [7:0]        value_B,
    output logic              load_A,
    output logic              load_B,
    output logic              clr_run_A,
    output logic              clr_run_B,
    output logic              set_run_A,
    output logic              set_run_B,
    output logic              clr_flag_A,
    output logic              clr_flag_B,
    output logic              enable_irq_A,
    output logic              enable_irq_B,
    input  wire logic         flag_A,
    input  wire logic         flag_B,
    input  wire logic         overflow_A,
    output logic              csm_kon
);

    logic       wr_last_q,  wr_last_d;
    logic [7:0] addr_q,     addr_d;
    logic [7:0] reg10_q,    reg10_d;
    logic [1:0] reg11_q,    reg11_d;
    logic [7:0] reg12_q,    reg12_d;
    logic       csm_q,      csm_d;
    logic       irqen_a_q,  irqen_a_d;
    logic       irqen_b_q,  irqen_b_d;
    logic       run_a_q,    run_a_d;
    logic       run_b_q,    run_b_d;
    tmr_cmd_t   pend_q,     pend_d;
    tmr_cmd_t   cmd_q,      cmd_d;
    logic [1:0] irq_out_q,  irq_out_d;
    logic       csm_kon_q,  csm_kon_d;
    logic [9:0] value_a_q,  value_a_d;
    logic [7:0] value_b_q,  value_b_d;
    logic [7:0] dout_q,     dout_d;

    logic wr_now;
    logic write_ev;
    logic data_wr;
    logic busy;

    assign wr_now   = ~bus.cs_n & ~bus.wr_n;
    assign write_ev = wr_now & ~wr_last_q;
    assign data_wr  = write_ev & bus.a0;

    jt51_busy_cnt #(
        .BUSY_CYC (BUSY_CYC)
    ) u_busy_cnt (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .load (data_wr),
        .busy (busy)
    );

    always_comb begin
        wr_last_d = wr_now;
        addr_d    = addr_q;
        reg10_d   = reg10_q;
        reg11_d   = reg11_q;
        reg12_d   = reg12_q;
        csm_d     = csm_q;
        irqen_a_d = irqen_a_q;
        irqen_b_d = irqen_b_q;
        run_a_d   = run_a_q;
        run_b_d   = run_b_q;
        // Pending commands are handed to the outputs on a cen cycle, so that cycle starts empty.
        pend_d    = cen ? '0 : pend_q;

        if (write_ev && !bus.a0) begin
            addr_d = bus.din;
        end

        if (data_wr) begin
            case (addr_q)
                ADDR_CLKA1: reg10_d = bus.din;
                ADDR_CLKA2: reg11_d = bus.din[1:0];
                ADDR_CLKB:  reg12_d = bus.din;
                ADDR_TCTRL: begin
                    csm_d     = bus.din[TCTRL_CSM];
                    irqen_a_d = bus.din[TCTRL_IRQEN_A];
                    irqen_b_d = bus.din[TCTRL_IRQEN_B];
                    run_a_d   = bus.din[TCTRL_LOAD_A];
                    run_b_d   = bus.din[TCTRL_LOAD_B];
                    // Only run-level edges issue commands; the newest edge overrides an older one.
                    if (bus.din[TCTRL_LOAD_A] && !run_a_q) begin
                        pend_d.load_a    = 1'b1;
                        pend_d.clr_run_a = 1'b0;
                    end else if (!bus.din[TCTRL_LOAD_A] && run_a_q) begin
                        pend_d.clr_run_a = 1'b1;
                        pend_d.load_a    = 1'b0;
                    end
                    if (bus.din[TCTRL_LOAD_B] && !run_b_q) begin
                        pend_d.load_b    = 1'b1;
                        pend_d.clr_run_b = 1'b0;
                    end else if (!bus.din[TCTRL_LOAD_B] && run_b_q) begin
                        pend_d.clr_run_b = 1'b1;
                        pend_d.load_b    = 1'b0;
                    end
                    if (bus.din[TCTRL_FRES_A]) pend_d.clr_flag_a = 1'b1;
                    if (bus.din[TCTRL_FRES_B]) pend_d.clr_flag_b = 1'b1;
                end
                default: ;
            endcase
        end

        cmd_d     = cen ? pend_q : cmd_q;
        irq_out_d = cen ? {irqen_b_q, irqen_a_q} : irq_out_q;
        csm_kon_d = cen ? (overflow_A & csm_q) : csm_kon_q;
        value_a_d = {reg10_q, reg11_q};
        value_b_d = reg12_q;
        dout_d    = '0;
        dout_d[STATUS_BUSY_BIT] = busy;
        dout_d[1:0] = {flag_B, flag_A};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_last_q <= 1'b0;
            addr_q    <= '0;
            reg10_q   <= '0;
            reg11_q   <= '0;
            reg12_q   <= '0;
            csm_q     <= 1'b0;
            irqen_a_q <= 1'b0;
            irqen_b_q <= 1'b0;
            run_a_q   <= 1'b0;
            run_b_q   <= 1'b0;
            pend_q    <= '0;
            cmd_q     <= '0;
            irq_out_q <= '0;
            csm_kon_q <= 1'b0;
            value_a_q <= '0;
            value_b_q <= '0;
            dout_q    <= '0;
        end else begin
            wr_last_q <= wr_last_d;
            addr_q    <= addr_d;
            reg10_q   <= reg10_d;
            reg11_q   <= reg11_d;
            reg12_q   <= reg12_d;
            csm_q     <= csm_d;
            irqen_a_q <= irqen_a_d;
            irqen_b_q <= irqen_b_d;
            run_a_q   <= run_a_d;
            run_b_q   <= run_b_d;
            pend_q    <= pend_d;
            cmd_q     <= cmd_d;
            irq_out_q <= irq_out_d;
            csm_kon_q <= csm_kon_d;
            value_a_q <= value_a_d;
            value_b_q <= value_b_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.dout     = dout_q;
    assign value_A      = value_a_q;
    assign value_B      = value_b_q;
    assign load_A       = cmd_q.load_a;
    assign load_B       = cmd_q.load_b;
    assign clr_run_A    = cmd_q.clr_run_a;
    assign clr_run_B    = cmd_q.clr_run_b;
    assign clr_flag_A   = cmd_q.clr_flag_a;
    assign clr_flag_B   = cmd_q.clr_flag_b;
    assign set_run_A    = 1'b0;
    assign set_run_B    = 1'b0;
    assign enable_irq_A = irq_out_q[0];
    assign enable_irq_B = irq_out_q[1];
    assign csm_kon      = csm_kon_q;

endmodule

`default_nettype wire
